// File: rtl/dmux_stream_if.sv
// Stream bundle for dmux_stream: one producer port in, OUTPUT_COUNT consumer lanes out.
// Handshake: a beat moves on a port/lane in any cycle where its valid and ready are both high.
interface dmux_stream_if #(
    parameter int WIDTH        = 8,
    parameter int OUTPUT_COUNT = 4,
    parameter int SEL_W        = $clog2(OUTPUT_COUNT)
);
    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH-1:0]              in;
    logic [SEL_W-1:0]              sel;
    logic [OUTPUT_COUNT-1:0]       mask;
    logic [WIDTH*OUTPUT_COUNT-1:0] out;
    logic [OUTPUT_COUNT-1:0]       out_valid;
    logic [OUTPUT_COUNT-1:0]       out_ready;
    logic                          drop;

    // slave: the demux itself; master: the producer/consumer environment around it
    modport slave (
        input  in_valid, in, sel, mask, out_ready,
        output in_ready, out, out_valid, drop
    );
    modport master (
        output in_valid, in, sel, mask, out_ready,
        input  in_ready, out, out_valid, drop
    );
endinterface

// File: rtl/dmux_stream.sv
// Pipelined 1-to-N stream demultiplexer with per-lane valid/ready, collapsing bubbles
// and optional multicast (MODE=1) where a beat retires once every addressed lane took it.
module dmux_stream #(
    parameter int WIDTH        = 8,
    parameter int OUTPUT_COUNT = 4,
    parameter int STAGES       = 2,
    parameter int MODE         = 0,
    parameter int SEL_W        = $clog2(OUTPUT_COUNT)
) (
    input  logic          clk,
    input  logic          rst,
    dmux_stream_if.slave  bus
);
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0]       v_q, v_d, free;
    logic [WIDTH-1:0]        data_q [STAGES];
    logic [WIDTH-1:0]        data_d [STAGES];
    logic [OUTPUT_COUNT-1:0] dest_q [STAGES];
    logic [OUTPUT_COUNT-1:0] dest_d [STAGES];
    logic [OUTPUT_COUNT-1:0] done_q, done_d;
    logic [OUTPUT_COUNT-1:0] dest_in, lane_valid, xfer;
    logic                    drop_q, drop_d;
    logic                    retire, accept, legal;

    always_comb begin : route
        dest_in = '0;
        if (MODE == 0) begin
            for (int i = 0; i < OUTPUT_COUNT; i++) dest_in[i] = (int'(bus.sel) == i);
        end else begin
            dest_in = bus.mask;
        end
        // An out-of-range sel and an empty mask both leave no destination bit set.
        legal = (dest_in != '0);
    end

    always_comb begin : flow
        logic all_full;
        lane_valid = {OUTPUT_COUNT{v_q[LAST]}} & dest_q[LAST] & ~done_q;
        xfer       = lane_valid & bus.out_ready;
        retire     = v_q[LAST] && ((dest_q[LAST] & ~(done_q | xfer)) == '0);
        // Stage k can take a beat if any stage at or after it is empty, or the tail retires.
        all_full = 1'b1;
        free     = '0;
        for (int k = LAST; k >= 0; k--) begin
            all_full = all_full & v_q[k];
            free[k]  = retire || !all_full;
        end
        accept = bus.in_valid && free[0] && !rst;
    end

    always_comb begin : next_state
        v_d    = v_q;
        data_d = data_q;
        dest_d = dest_q;
        if (free[0]) begin
            v_d[0] = accept && legal;
            if (accept && legal) begin
                data_d[0] = bus.in;
                dest_d[0] = dest_in;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (free[k]) begin
                v_d[k]    = v_q[k-1];
                data_d[k] = data_q[k-1];
                dest_d[k] = dest_q[k-1];
            end
        end
        done_d = retire ? '0 : (done_q | xfer);
        drop_d = accept && !legal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            done_q <= '0;
            drop_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                dest_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            done_q <= done_d;
            drop_q <= drop_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
                dest_q[k] <= dest_d[k];
            end
        end
    end

    always_comb begin : outputs
        bus.in_ready  = free[0] && !rst;
        bus.out_valid = lane_valid;
        bus.drop      = drop_q;
        bus.out       = '0;
        for (int i = 0; i < OUTPUT_COUNT; i++) begin
            if (lane_valid[i]) bus.out[i*WIDTH +: WIDTH] = data_q[LAST];
        end
    end
endmodule
